// File: rtl/sweep_pkg.sv
// Shared defaults and FSM state encoding for the phase sweep generator.
package sweep_pkg;

    // Phase-increment width matches the downstream NCO/CORDIC accumulator.
    localparam int PW_DEFAULT = 19;
    // Width of the per-value dwell counter.
    localparam int DW_DEFAULT = 16;

    // Sweep controller states. The down leg of a bidirectional sweep is a
    // direction flag inside RUN, not a separate state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell counter: holds each sweep value for max(value,1) enabled cycles and
// pulses expire_o in the last cycle of the dwell.
module sweep_dwell_timer #(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [DW-1:0] value_i,
    output logic          expire_o
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] load_val;

    // A dwell of zero behaves exactly like a dwell of one.
    assign load_val = (value_i == '0) ? {{(DW-1){1'b0}}, 1'b1} : value_i;

    // The count reaches 1 in the final cycle of the dwell.
    assign expire_o = en_i && (cnt_q == {{(DW-1){1'b0}}, 1'b1});

    // Load on request, otherwise count down while enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/phase_sweep_gen.sv
// Phase-increment sweep generator feeding an NCO phase_inc input.
// Sweeps from f_start toward f_stop in steps of 'step', holding each value
// for 'dwell' cycles, with optional looping and abort.
// Optional feature: define SWEEP_BIDIR_EN to add a down leg from f_stop back
// to f_start after the up leg (triangle instead of sawtooth).
module phase_sweep_gen
    import sweep_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    input  logic [PW-1:0] f_start,
    input  logic [PW-1:0] f_stop,
    input  logic [PW-1:0] step,
    input  logic [DW-1:0] dwell,
    output logic [PW-1:0] phase_inc,
    output logic          busy,
    output logic          step_stb,
    output logic          done
);

    sweep_state_e  state_q;
    logic [PW-1:0] f_start_q;
    logic [PW-1:0] f_stop_q;
    logic [PW-1:0] step_q;
    logic [DW-1:0] dwell_q;
    logic          at_end_q;     // current value is the end point of this leg
    logic [PW-1:0] phase_inc_q;
    logic          busy_q;
    logic          step_stb_q;
    logic          done_q;

    logic          start_accept;
    logic          in_run;
    logic          timer_load;
    logic          timer_en;
    logic          timer_expire;
    logic [DW-1:0] timer_value;
    logic [PW:0]   up_sum;
    logic          up_hit;
    logic          last_leg;

    assign start_accept = (state_q == IDLE) && start && !abort;
    assign in_run       = (state_q == RUN);
    assign timer_en     = in_run && !abort;
    assign timer_load   = start_accept || (in_run && timer_expire && !abort);
    // Config is taken live only on the start edge; afterwards the latched copy.
    assign timer_value  = start_accept ? dwell : dwell_q;

    // Up-leg step with one extra bit so the compare never sees a wrapped sum.
    // A zero step would never reach f_stop, so it jumps there directly.
    assign up_sum = {1'b0, phase_inc_q} + {1'b0, step_q};
    assign up_hit = (up_sum >= {1'b0, f_stop_q}) || (step_q == '0);

`ifdef SWEEP_BIDIR_EN
    logic          dir_q;        // 1 = down leg
    logic [PW:0]   dn_diff;
    logic          dn_hit;
    // Down-leg step; the extra MSB flags underflow. A zero step would never
    // descend, so it lands on f_start directly.
    assign dn_diff  = {1'b0, phase_inc_q} - {1'b0, step_q};
    assign dn_hit   = dn_diff[PW] || (dn_diff[PW-1:0] <= f_start_q) || (step_q == '0);
    assign last_leg = dir_q;
`else
    assign last_leg = 1'b1;
`endif

    sweep_dwell_timer #(
        .DW (DW)
    ) u_dwell_timer (
        .clk_i    (sys_clk),
        .rst_i    (rst),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .value_i  (timer_value),
        .expire_o (timer_expire)
    );

    // Sweep FSM with registered outputs; abort overrides every state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            f_start_q   <= '0;
            f_stop_q    <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            at_end_q    <= 1'b0;
            phase_inc_q <= '0;
            busy_q      <= 1'b0;
            step_stb_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir_q       <= 1'b0;
`endif
        end else if (abort) begin
            // Cancel: phase_inc stays where it was, no pulses.
            state_q    <= IDLE;
            at_end_q   <= 1'b0;
            busy_q     <= 1'b0;
            step_stb_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            step_stb_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f_start_q   <= f_start;
                        f_stop_q    <= f_stop;
                        step_q      <= step;
                        dwell_q     <= dwell;
                        at_end_q    <= 1'b0;
                        phase_inc_q <= f_start;
                        busy_q      <= 1'b1;
                        step_stb_q  <= 1'b1;
                        state_q     <= RUN;
`ifdef SWEEP_BIDIR_EN
                        dir_q       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (timer_expire) begin
                        if (at_end_q && last_leg) begin
                            // End point reached and its dwell is over.
                            if (loop) begin
                                phase_inc_q <= f_start_q;
                                step_stb_q  <= 1'b1;
                                at_end_q    <= 1'b0;
`ifdef SWEEP_BIDIR_EN
                                dir_q       <= 1'b0;
`endif
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
`ifdef SWEEP_BIDIR_EN
                        else if (dir_q || at_end_q) begin
                            // Turnaround at f_stop or a further down step.
                            dir_q      <= 1'b1;
                            step_stb_q <= 1'b1;
                            if (dn_hit) begin
                                phase_inc_q <= f_start_q;
                                at_end_q    <= 1'b1;
                            end else begin
                                phase_inc_q <= dn_diff[PW-1:0];
                                at_end_q    <= 1'b0;
                            end
                        end
`endif
                        else begin
                            step_stb_q <= 1'b1;
                            if (up_hit) begin
                                phase_inc_q <= f_stop_q;
                                at_end_q    <= 1'b1;
                            end else begin
                                phase_inc_q <= up_sum[PW-1:0];
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign phase_inc = phase_inc_q;
    assign busy      = busy_q;
    assign step_stb  = step_stb_q;
    assign done      = done_q;

endmodule
